// File: rtl/multiples_sum_engine.sv
// rtl/multiples_sum_engine.sv - sums naturals below limit that are multiples of any of N_DIV divisors
// Optional hit counter output enabled by defining MULT_SUM_HITS_EN.
module multiples_sum_engine #(
    parameter int W     = 16,
    parameter int SUM_W = 32,
    parameter int N_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W-1:0]       limit,
    input  logic [N_DIV*W-1:0] div_flat,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   sum,
    output logic               overflow,
    output logic               err
`ifdef MULT_SUM_HITS_EN
    ,
    output logic [W-1:0]       hits
`endif
);

    // Adder is wide enough for both operands plus a carry bit, whichever is wider.
    localparam int AW = ((SUM_W > W + 1) ? SUM_W : W + 1) + 1;
    localparam logic [W:0] N_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [W:0]         n_q;
    logic [W-1:0]       lim_q;
    logic [W-1:0]       d_q [N_DIV];
    logic [W-1:0]       r_q [N_DIV];
    logic [SUM_W-1:0]   sum_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic               err_q;
`ifdef MULT_SUM_HITS_EN
    logic [W-1:0]       hits_q;
`endif

    logic               hit_d;
    logic               zero_div_d;
    logic [AW-1:0]      acc_d;

    always_comb begin
        hit_d      = 1'b0;
        zero_div_d = 1'b0;
        for (int i = 0; i < N_DIV; i++) begin
            if (r_q[i] == '0) hit_d = 1'b1;
            if (div_flat[i*W +: W] == '0) zero_div_d = 1'b1;
        end
        acc_d = AW'(sum_q) + AW'(n_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            lim_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_DIV; i++) begin
                d_q[i] <= '0;
                r_q[i] <= '0;
            end
`ifdef MULT_SUM_HITS_EN
            hits_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        lim_q <= limit;
                        sum_q <= '0;
                        ovf_q <= 1'b0;
                        n_q   <= N_ONE;
`ifdef MULT_SUM_HITS_EN
                        hits_q <= '0;
`endif
                        for (int i = 0; i < N_DIV; i++) begin
                            d_q[i] <= div_flat[i*W +: W];
                            r_q[i] <= (div_flat[i*W +: W] == W'(1)) ? '0 : W'(1);
                        end
                        // A zero divisor skips RUN; FIN then spends one silent cycle first.
                        if (zero_div_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (n_q < {1'b0, lim_q}) begin
                        if (hit_d) begin
                            sum_q <= acc_d[SUM_W-1:0];
                            if (|acc_d[AW-1:SUM_W]) ovf_q <= 1'b1;
`ifdef MULT_SUM_HITS_EN
                            hits_q <= hits_q + W'(1);
`endif
                        end
                        n_q <= n_q + N_ONE;
                        for (int i = 0; i < N_DIV; i++) begin
                            r_q[i] <= (r_q[i] == d_q[i] - W'(1)) ? '0 : r_q[i] + W'(1);
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign overflow = ovf_q;
    assign err      = err_q;
`ifdef MULT_SUM_HITS_EN
    assign hits     = hits_q;
`endif

endmodule

// File: tb/tb_multiples_sum_engine.sv
// tb/tb_multiples_sum_engine.sv - directed self-checking bench for multiples_sum_engine
module tb_multiples_sum_engine;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  limit = '0;
    logic [2*W-1:0] div_flat = '0;
    logic          busy, done, overflow, err;
    logic [31:0]   sum;

    logic          start8 = 1'b0;
    logic [W-1:0]  limit8 = '0;
    logic [2*W-1:0] div8 = '0;
    logic          busy8, done8, overflow8, err8;
    logic [7:0]    sum8;

`ifdef MULT_SUM_HITS_EN
    logic [W-1:0]  hits, hits8;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multiples_sum_engine #(.W(W), .SUM_W(32), .N_DIV(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .div_flat(div_flat),
        .busy(busy), .done(done), .sum(sum), .overflow(overflow), .err(err)
`ifdef MULT_SUM_HITS_EN
        , .hits(hits)
`endif
    );

    multiples_sum_engine #(.W(W), .SUM_W(8), .N_DIV(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .limit(limit8), .div_flat(div8),
        .busy(busy8), .done(done8), .sum(sum8), .overflow(overflow8), .err(err8)
`ifdef MULT_SUM_HITS_EN
        , .hits(hits8)
`endif
    );

    // Pulses start for one edge, then counts cycles (and busy cycles) until done or the budget expires.
    task automatic run(input logic [W-1:0] lim, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       output int lat, output int bcnt);
        @(negedge clk);
        limit = lim;
        div_flat = {d1, d0};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 3000) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({busy, done, overflow, err} !== 4'b0 || sum !== 32'd0) begin
            $display("FAIL reset_outputs got busy=%b done=%b ovf=%b err=%b sum=%0d expected all 0",
                     busy, done, overflow, err, sum);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run(16'd10, 16'd3, 16'd5, lat, bcnt);
        n_total++;
        if (lat !== 10) $display("FAIL basic_latency got %0d expected 10", lat); else n_pass++;
        n_total++;
        if (sum !== 32'd23) $display("FAIL basic_sum got %0d expected 23", sum); else n_pass++;
        n_total++;
        if (overflow !== 1'b0 || err !== 1'b0)
            $display("FAIL basic_flags got ovf=%b err=%b expected 0 0", overflow, err);
        else n_pass++;
        n_total++;
        if (bcnt !== 10) $display("FAIL basic_busy_cycles got %0d expected 10", bcnt); else n_pass++;
`ifdef MULT_SUM_HITS_EN
        n_total++;
        if (hits !== 16'd4) $display("FAIL basic_hits got %0d expected 4", hits); else n_pass++;
`endif
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || sum !== 32'd23)
            $display("FAIL basic_done_pulse got done=%b sum=%0d expected done=0 sum=23", done, sum);
        else n_pass++;
    endtask

    task automatic test_large();
        int lat, bcnt;
        run(16'd1000, 16'd3, 16'd5, lat, bcnt);
        n_total++;
        if (sum !== 32'd233168) $display("FAIL large_sum got %0d expected 233168", sum); else n_pass++;
        n_total++;
        if (bcnt !== 1000) $display("FAIL large_busy_cycles got %0d expected 1000", bcnt); else n_pass++;
        n_total++;
        if (lat !== 1000 || overflow !== 1'b0 || err !== 1'b0)
            $display("FAIL large_done got lat=%0d ovf=%b err=%b expected 1000 0 0", lat, overflow, err);
        else n_pass++;
`ifdef MULT_SUM_HITS_EN
        n_total++;
        if (hits !== 16'd466) $display("FAIL large_hits got %0d expected 466", hits); else n_pass++;
`endif
    endtask

    task automatic test_dup_and_zero_limit();
        int lat, bcnt;
        run(16'd16, 16'd3, 16'd5, lat, bcnt);
        n_total++;
        if (sum !== 32'd60) $display("FAIL limit16_sum got %0d expected 60", sum); else n_pass++;
`ifdef MULT_SUM_HITS_EN
        n_total++;
        if (hits !== 16'd7) $display("FAIL limit16_hits got %0d expected 7", hits); else n_pass++;
`endif
        run(16'd0, 16'd3, 16'd5, lat, bcnt);
        n_total++;
        if (lat !== 1 || sum !== 32'd0)
            $display("FAIL limit0 got lat=%0d sum=%0d expected lat=1 sum=0", lat, sum);
        else n_pass++;
        run(16'd1, 16'd3, 16'd3, lat, bcnt);
        n_total++;
        if (lat !== 1 || sum !== 32'd0 || bcnt !== 1)
            $display("FAIL limit1 got lat=%0d sum=%0d busy=%0d expected 1 0 1", lat, sum, bcnt);
        else n_pass++;
    endtask

    task automatic test_err();
        int lat, bcnt;
        run(16'd20, 16'd0, 16'd5, lat, bcnt);
        n_total++;
        if (lat !== 1) $display("FAIL err_latency got %0d expected 1", lat); else n_pass++;
        n_total++;
        if (err !== 1'b1 || sum !== 32'd0)
            $display("FAIL err_result got err=%b sum=%0d expected err=1 sum=0", err, sum);
        else n_pass++;
        n_total++;
        if (bcnt !== 0) $display("FAIL err_busy got %0d busy cycles expected 0", bcnt); else n_pass++;
`ifdef MULT_SUM_HITS_EN
        n_total++;
        if (hits !== 16'd0) $display("FAIL err_hits got %0d expected 0", hits); else n_pass++;
`endif
    endtask

    task automatic test_overflow();
        int lat;
        @(negedge clk);
        limit8 = 16'd30;
        div8 = {16'd1, 16'd1};
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat !== 30) $display("FAIL ovf_latency got %0d expected 30", lat); else n_pass++;
        n_total++;
        if (sum8 !== 8'd179) $display("FAIL ovf_sum got %0d expected 179", sum8); else n_pass++;
        n_total++;
        if (overflow8 !== 1'b1 || err8 !== 1'b0)
            $display("FAIL ovf_flag got ovf=%b err=%b expected 1 0", overflow8, err8);
        else n_pass++;
`ifdef MULT_SUM_HITS_EN
        n_total++;
        if (hits8 !== 16'd29) $display("FAIL ovf_hits got %0d expected 29", hits8); else n_pass++;
`endif
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        limit = 16'd100;
        div_flat = {16'd5, 16'd3};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 3000) begin
            if (lat == 5) begin
                limit = 16'd10;
                div_flat = {16'd0, 16'd2};
                start = 1'b1;
            end
            if (lat == 8) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat !== 100 || sum !== 32'd2318 || err !== 1'b0)
            $display("FAIL start_ignored got lat=%0d sum=%0d err=%b expected 100 2318 0", lat, sum, err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || sum !== 32'd2318)
            $display("FAIL start_not_queued got busy=%b sum=%0d expected 0 2318", busy, sum);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int lat, bcnt;
        @(negedge clk);
        limit = 16'd1000;
        div_flat = {16'd5, 16'd3};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || sum === 32'd0)
            $display("FAIL midrun_active got busy=%b sum=%0d expected busy=1 sum nonzero", busy, sum);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'd0 || overflow !== 1'b0 || err !== 1'b0)
            $display("FAIL midrun_reset got busy=%b done=%b sum=%0d ovf=%b err=%b expected all 0",
                     busy, done, sum, overflow, err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) lat++;
        end
        n_total++;
        if (lat !== 0) $display("FAIL midrun_no_done got %0d done cycles expected 0", lat); else n_pass++;
        run(16'd10, 16'd3, 16'd5, lat, bcnt);
        n_total++;
        if (sum !== 32'd23 || lat !== 10)
            $display("FAIL after_reset got sum=%0d lat=%0d expected 23 10", sum, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large();
        test_dup_and_zero_limit();
        test_err();
        test_overflow();
        test_start_ignored();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multiples_sum_engine.md
Name: multiples_sum_engine

Overview:
- Self-sequenced engine that sums every natural n with 1 <= n < limit that is a multiple of at least one of N_DIV runtime divisors. With N_DIV=2 and divisors 3 and 5, it produces the classic "multiples of 3 or 5" result.
- It supersedes the externally-controlled 3/5/15 datapath. The controller is now internal, the width, sum width and divisor count are parameters, and the block reports divide-by-zero and overflow.
- It sits behind a start/done handshake and is driven by the top-level sequencer or the switch front-end.

Parameters:
- W, 16, width of limit and of each divisor.
- SUM_W, 32, width of the sum accumulator.
- N_DIV, 2, number of divisors (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a computation; sampled only in IDLE.
- limit  in  W  exclusive upper bound; latched on an accepted start.
- div_flat  in  N_DIV*W  divisors packed as div i = div_flat[i*W +: W]; latched on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is valid.
- sum  out  SUM_W  result; held until the next accepted start.
- overflow  out  1  sticky for the current run; set if the accumulator wrapped.
- err  out  1  set when any latched divisor is 0; held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert handled outside the block): state=IDLE; busy=0, done=0, sum=0, overflow=0, err=0; internal n=0, residues=0.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN on start=1:
  - Latch limit and the divisors.
  - Clear sum, overflow and err.
  - Set n=1.
  - Set each residue r_i = (d_i==1) ? 0 : 1.
- IDLE with any latched d_i==0 -> FIN directly: err=1, sum=0, no RUN cycles.
- RUN, per clock, when n < limit:
  - hit = OR over i of (r_i==0).
  - If hit, sum <= sum + n (zero-extended, modulo 2^SUM_W). A carry out sets overflow.
  - n <= n+1.
  - Each r_i <= (r_i == d_i-1) ? 0 : r_i+1. No divider or modulo operator is used.
- RUN with n >= limit -> FIN; no accumulate on that cycle.
- FIN: done=1 for exactly one cycle, busy=0, then -> IDLE.
- Latency: with limit >= 1, done is high in the cycle after edge (start edge + limit). With limit = 0, done is high after start edge + 1. The err path takes start edge + 1.
- busy is high in RUN cycles only.
- start while in RUN or FIN is ignored, and is not queued.
- limit=0 or 1: sum=0, done after 1 RUN cycle.
- n is W+1 bits internally so that limit = 2^W-1 terminates without wrap.
- Reset mid-run aborts immediately. All outputs take their reset values; no done pulse is produced.
- Divisors > limit never hit, which is legal. Duplicate divisors are counted once, because the hit test is an OR.

Optional Feature:
- Macro MULT_SUM_HITS_EN.
- When defined:
  - Adds output hits [W-1:0]: the number of n that hit in the current run.
  - Cleared on an accepted start and on reset; incremented alongside each accumulate.
  - Valid with done and held until the next start.
  - On the err path it stays 0.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- N_DIV=2, divisors 3,5, limit=10, one start pulse -> done in the cycle after start edge + 10; sum=23, overflow=0, err=0. With MULT_SUM_HITS_EN, hits=4.
- Divisors 3,5, limit=1000 -> sum=233168, err=0, overflow=0. busy is high for exactly 1000 cycles.
- Divisors 3,5, limit=16 -> sum=60 (15 counted once). Then limit=0 -> sum=0, done one cycle after start.
- Divisors 0,5, limit=20 -> done one cycle after start; err=1, sum=0, busy never asserted.
- SUM_W=8, divisors 1,1, limit=30 -> sum=179 (435 mod 256), overflow=1.
- Assert start during RUN -> ignored, with the result unchanged. Drop rst_n mid-run with divisors 3,5 and limit=1000 -> busy, done and sum go to 0 immediately. A fresh start with limit=10 afterwards -> sum=23.
